// File: rtl/ps2_key_controller.sv
// ps2_key_controller: synchronous PS/2 keyboard receiver with make/break/extended
// decode and a small valid/ready event FIFO.
`default_nettype none

module ps2_key_controller #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TIMEOUT_US  = 2000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overflow
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW             = $clog2(FIFO_DEPTH);
  localparam int CNT_W          = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;

  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_timeout;

  logic w_accept, w_perr, w_ferr;
  logic r_ext, r_brk;
  logic r_parity_err, r_frame_err, r_overflow;

  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full, w_pop, w_push_req, w_push;
  logic [9:0]       w_push_data;

  // Sync flops reset to the idle-high line level so release never fakes an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= PS2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= PS2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_s2;
  assign w_timeout = (r_state != IDLE) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_perr   = 1'b0;
    w_ferr   = 1'b0;
    if (w_timeout) begin
      w_next = IDLE;
      w_ferr = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        IDLE:   if (!r_dat_s2) w_next = DATA;
        DATA:   if (r_bit_cnt == 3'd7) w_next = PARITY;
        PARITY: w_next = STOP;
        STOP: begin
          w_next = IDLE;
          // A bad stop bit masks any parity result.
          if (!r_dat_s2) begin
            w_ferr = 1'b1;
          end else if (^{r_shift, r_parity}) begin
            w_accept = 1'b1;
          end else begin
            w_perr = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
    end else if (w_fall && !w_timeout) begin
      case (r_state)
        IDLE: r_bit_cnt <= '0;
        DATA: begin
          r_shift[r_bit_cnt] <= r_dat_s2;
          r_bit_cnt          <= r_bit_cnt + 3'd1;
        end
        PARITY:  r_parity <= r_dat_s2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == IDLE || w_fall || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_push_req  = w_accept && (r_shift != 8'hE0) && (r_shift != 8'hF0);
  assign w_push_data = {r_shift, r_brk, r_ext};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_perr || w_ferr) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_accept) begin
      if (r_shift == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_shift == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign key_valid = (r_count != '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = key_valid & key_ready;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign w_push    = w_push_req & (~w_full | w_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      r_overflow <= w_push_req & w_full & ~w_pop;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_parity_err <= w_perr;
      r_frame_err  <= w_ferr;
    end
  end

  assign key_code     = key_valid ? r_mem[r_rd_ptr][9:2] : 8'h00;
  assign key_release  = key_valid ? r_mem[r_rd_ptr][1]   : 1'b0;
  assign key_extended = key_valid ? r_mem[r_rd_ptr][0]   : 1'b0;
  assign parity_error = r_parity_err;
  assign frame_error  = r_frame_err;
  assign overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_controller.sv
// tb_ps2_key_controller: directed frames with hand-computed expected key events.
`default_nettype none

module tb_ps2_key_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       PS2_clk = 1'b1;
  logic       PS2_data = 1'b1;
  logic       key_ready = 1'b1;
  logic       key_valid, key_release, key_extended;
  logic [7:0] key_code;
  logic       parity_error, frame_error, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;
  logic [9:0] evq[$];

  int ev0, p0, f0, o0;

  // 50 us at 1 MHz gives a 50-cycle timeout; PS/2 edges come every 16 cycles.
  ps2_key_controller #(
    .CLK_FREQ_HZ(1000000),
    .TIMEOUT_US (50),
    .FIFO_DEPTH (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .PS2_clk     (PS2_clk),
    .PS2_data    (PS2_data),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_release (key_release),
    .key_extended(key_extended),
    .parity_error(parity_error),
    .frame_error (frame_error),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (key_valid && key_ready) evq.push_back({key_code, key_release, key_extended});
    if (parity_error) perr_cnt++;
    if (frame_error)  ferr_cnt++;
    if (overflow)     ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                           input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      PS2_data = f[i];
      tick(8);
      PS2_clk = 1'b0;
      tick(8);
      PS2_clk = 1'b1;
    end
    PS2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par = 1'b0,
                           input logic bad_stop = 1'b0);
    send_bits(mk_frame(b, bad_par, bad_stop), 0, 10);
    tick(20);
  endtask

  task automatic mark;
    ev0 = evq.size();
    p0  = perr_cnt;
    f0  = ferr_cnt;
    o0  = ovf_cnt;
  endtask

  function automatic logic [9:0] ev_at(input int idx);
    if (idx < evq.size()) return evq[idx];
    return 10'h3FF;
  endfunction

  initial begin
    tick(3);
    check("reset_valid", key_valid, 0);
    check("reset_code", key_code, 0);
    check("reset_errs", {parity_error, frame_error, overflow}, 0);
    reset_n = 1'b1;
    tick(5);

    mark();
    send_byte(8'h1C);
    check("make1c_count", evq.size() - ev0, 1);
    check("make1c_event", ev_at(ev0), {8'h1C, 1'b0, 1'b0});
    check("make1c_noerr", (perr_cnt - p0) + (ferr_cnt - f0), 0);

    mark();
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("brk_count", evq.size() - ev0, 1);
    check("brk_event", ev_at(ev0), {8'h1C, 1'b1, 1'b0});

    mark();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("extbrk_count", evq.size() - ev0, 1);
    check("extbrk_event", ev_at(ev0), {8'h75, 1'b1, 1'b1});

    mark();
    send_byte(8'h29, 1'b1);
    check("par_pulse", perr_cnt - p0, 1);
    check("par_noevent", evq.size() - ev0, 0);
    send_byte(8'h29);
    check("par_recover", ev_at(ev0), {8'h29, 1'b0, 1'b0});

    mark();
    send_byte(8'hE0);
    send_byte(8'h5A, 1'b1, 1'b1);
    send_byte(8'h5A);
    check("stop_ferr", ferr_cnt - f0, 1);
    check("stop_no_perr", perr_cnt - p0, 0);
    check("stop_flags_cleared", ev_at(ev0), {8'h5A, 1'b0, 1'b0});

    mark();
    send_bits(mk_frame(8'h23, 1'b0, 1'b0), 0, 4);
    tick(80);
    check("tmo_ferr", ferr_cnt - f0, 1);
    check("tmo_noevent", evq.size() - ev0, 0);
    send_byte(8'h23);
    check("tmo_recover", ev_at(ev0), {8'h23, 1'b0, 1'b0});

    mark();
    key_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'h23);
    send_byte(8'h29);
    send_byte(8'h76);
    check("ovf_none_yet", ovf_cnt - o0, 0);
    send_byte(8'h1B);
    check("ovf_pulse", ovf_cnt - o0, 1);
    check("ovf_head_valid", key_valid, 1);
    check("ovf_head_code", key_code, 8'h1C);
    key_ready = 1'b1;
    tick(4);
    check("drain_empty", key_valid, 0);
    check("drain_count", evq.size() - ev0, 4);
    check("drain_0", ev_at(ev0 + 0), {8'h1C, 2'b00});
    check("drain_1", ev_at(ev0 + 1), {8'h23, 2'b00});
    check("drain_2", ev_at(ev0 + 2), {8'h29, 2'b00});
    check("drain_3", ev_at(ev0 + 3), {8'h76, 2'b00});
    check("drain_code_zero", key_code, 0);

    key_ready = 1'b0;
    send_byte(8'h16);
    check("pre_rst_valid", key_valid, 1);
    mark();
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 0, 5);
    reset_n = 1'b0;
    tick(2);
    check("rst_valid", key_valid, 0);
    check("rst_outs", {key_code, key_release, key_extended, parity_error, frame_error, overflow}, 0);
    reset_n = 1'b1;
    key_ready = 1'b1;
    tick(2);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 6, 10);
    tick(80);
    check("rst_remainder_noevent", evq.size() - ev0, 0);
    send_byte(8'h1C);
    check("rst_next_count", evq.size() - ev0, 1);
    check("rst_next_event", ev_at(ev0), {8'h1C, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
